// File: rtl/edge_detect_pkg.sv
// Shared definitions for the edge detector bank.
// Mode encodings, stretch counter width and the edge-event helper.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Wide enough for a stretch length of 1..15 cycles.
  localparam int STRETCH_W = 4;

  function automatic logic edge_event(
    input logic [1:0] mode,
    input logic       lvl,
    input logic       prev
  );
    logic ev;
    ev = 1'b0;
    unique case (1'b1)
      mode == MODE_RISE: ev = lvl & ~prev;
      mode == MODE_FALL: ev = ~lvl & prev;
      mode == MODE_BOTH: ev = lvl ^ prev;
      default:           ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: synchroniser, prev register, pulse stretcher, edge counter.
// Ports: Clock, Reset, din, mode, enable (warm-up done), clear -> level, pulse, count.
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 din,
  input  logic [1:0]           mode,
  input  logic                 enable,
  input  logic                 clear,
  output logic                 level,
  output logic                 pulse,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [STRETCH_W-1:0] RELOAD = STRETCH_W'(STRETCH);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   hit;
  logic [STRETCH_W-1:0]   stretch;
  logic [CNT_WIDTH-1:0]   cnt;

  // sync[0] takes the raw input; the last stage is the level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign hit   = enable & edge_event(mode, level, prev);

  // A new hit reloads, so back-to-back events extend the pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stretch <= '0;
    end else if (hit) begin
      stretch <= RELOAD;
    end else if (stretch != '0) begin
      stretch <= stretch - STRETCH_W'(1);
    end
  end

  assign pulse = (stretch != '0);

  // Clear beats a simultaneous hit; saturate at all-ones.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign count = cnt;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of CHANNELS edge detectors sharing one mode and a warm-up window.
// Ports: Clock, Reset, InData, Mode, ClearCount -> Level, Edge, AnyEdge, EdgeCount.
module edge_detect_bank
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [CHANNELS-1:0]           InData,
  input  logic [1:0]                    Mode,
  input  logic [CHANNELS-1:0]           ClearCount,
  output logic [CHANNELS-1:0]           Level,
  output logic [CHANNELS-1:0]           Edge,
  output logic                          AnyEdge,
  output logic [CHANNELS*CNT_WIDTH-1:0] EdgeCount
);

  // Hold off events until the synchroniser and prev have refilled,
  // so levels held through reset do not look like edges.
  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);

  logic [WARM_W-1:0] warm;
  logic              enable;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      warm <= WARM_W'(WARM);
    end else if (warm != '0) begin
      warm <= warm - WARM_W'(1);
    end
  end

  assign enable = (warm == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .STRETCH    (STRETCH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_ch (
      .Clock (Clock),
      .Reset (Reset),
      .din   (InData[i]),
      .mode  (Mode),
      .enable(enable),
      .clear (ClearCount[i]),
      .level (Level[i]),
      .pulse (Edge[i]),
      .count (EdgeCount[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign AnyEdge = |Edge;

endmodule

// File: tb/tb_edge_detect_bank.sv
// Self-checking bench for edge_detect_bank.
// Table vectors, hand-written corner sequences and a random run vs a model.
module tb_edge_detect_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int ST = 3;
  localparam int CW = 4;
  localparam int HN = 8192;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [CH-1:0]    InData;
  logic [1:0]       Mode;
  logic [CH-1:0]    ClearCount;
  logic [CH-1:0]    Level;
  logic [CH-1:0]    Edge;
  logic             AnyEdge;
  logic [CH*CW-1:0] EdgeCount;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  edge_detect_bank #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .STRETCH    (ST),
    .CNT_WIDTH  (CW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .InData    (InData),
    .Mode      (Mode),
    .ClearCount(ClearCount),
    .Level     (Level),
    .Edge      (Edge),
    .AnyEdge   (AnyEdge),
    .EdgeCount (EdgeCount)
  );

  // Reference model: input history indexed by clock edge number.
  logic [CH-1:0] inh [HN];
  int k   = 0;
  int rel = 0;
  int last_evt [CH];
  int cnt      [CH];

  // Level after edge j is the input sampled SS-1 edges earlier,
  // provided that sample came after the last reset edge.
  function automatic logic [CH-1:0] lvl_at(int j);
    if (j - SS + 1 <= rel) return '0;
    return inh[(j - SS + 1) % HN];
  endfunction

  function automatic int cnt_of(logic [CH*CW-1:0] v, int ch);
    return int'(v[ch*CW +: CW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [CH-1:0] d, input logic [1:0] m,
                     input logic [CH-1:0] clr, input logic r);
    logic [CH-1:0]    lv, pv, ev, e_edge;
    logic [CH*CW-1:0] e_cnt;
    InData = d;
    Mode = m;
    ClearCount = clr;
    Reset = r;
    @(posedge Clock);
    k++;
    inh[k % HN] = d;
    if (r) begin
      rel = k;
      for (int c = 0; c < CH; c++) begin
        last_evt[c] = -100;
        cnt[c] = 0;
      end
    end else begin
      lv = lvl_at(k - 1);
      pv = (k - 1 <= rel) ? '0 : lvl_at(k - 2);
      case (m)
        2'b00:   ev = lv & ~pv;
        2'b01:   ev = ~lv & pv;
        2'b10:   ev = lv ^ pv;
        default: ev = '0;
      endcase
      if (k - rel < SS + 2) ev = '0;
      for (int c = 0; c < CH; c++) begin
        if (ev[c]) begin
          last_evt[c] = k;
          cnt[c] = (cnt[c] + 1 > 15) ? 15 : cnt[c] + 1;
        end
        if (clr[c]) cnt[c] = 0;
      end
    end
    for (int c = 0; c < CH; c++) begin
      e_edge[c] = (k - last_evt[c] < ST);
      e_cnt[c*CW +: CW] = CW'(cnt[c]);
    end
    #1;
    chk("model_level", int'(Level), int'(lvl_at(k)));
    chk("model_edge", int'({AnyEdge, Edge}), int'({|e_edge, e_edge}));
    chk("model_count", int'(EdgeCount), int'(e_cnt));
  endtask

  task automatic settle(input logic [CH-1:0] d, input logic [1:0] m);
    cyc(d, m, '0, 1'b1);
    repeat (5) cyc(d, m, '0, 1'b0);
  endtask

  typedef struct {
    logic [CH-1:0] d;
    logic [CH-1:0] lvl;
    logic [CH-1:0] edg;
    int            c0;
  } vec_t;

  vec_t tbl [6];
  logic [CH-1:0] dv;
  int hi, rises;
  logic pe;

  initial begin
    InData = '0;
    Mode = 2'b00;
    ClearCount = '0;
    Reset = 1'b1;

    // Reset state
    cyc('0, 2'b00, '0, 1'b1);
    chk("reset_level", int'(Level), 0);
    chk("reset_edge", int'({AnyEdge, Edge}), 0);
    chk("reset_count", int'(EdgeCount), 0);

    // Rising edge on channel 0: pulse after edges t+2..t+4
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 0};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0000, 0};
    tbl[2] = '{4'b0001, 4'b0001, 4'b0001, 1};
    tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 1};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0001, 1};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 1};
    settle('0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].d, 2'b00, '0, 1'b0);
      chk($sformatf("tbl%0d_level", i), int'(Level), int'(tbl[i].lvl));
      chk($sformatf("tbl%0d_edge", i), int'(Edge), int'(tbl[i].edg));
      chk($sformatf("tbl%0d_any", i), int'(AnyEdge), int'(|tbl[i].edg));
      chk($sformatf("tbl%0d_cnt0", i), cnt_of(EdgeCount, 0), tbl[i].c0);
    end

    // Both edges vs falling only on channel 1
    for (int p = 0; p < 2; p++) begin
      Mode = (p == 0) ? 2'b10 : 2'b01;
      settle(4'b0010, Mode);
      hi = 0;
      repeat (5) begin
        cyc(4'b0000, Mode, '0, 1'b0);
        hi += int'(Edge[1]);
      end
      repeat (8) begin
        cyc(4'b0010, Mode, '0, 1'b0);
        hi += int'(Edge[1]);
      end
      chk($sformatf("toggle_m%0d_hi", p), hi, (p == 0) ? 6 : 3);
      chk($sformatf("toggle_m%0d_cnt", p), cnt_of(EdgeCount, 1),
          (p == 0) ? 2 : 1);
    end

    // Fast toggling: continuous pulse and saturation on channel 2
    settle('0, 2'b10);
    dv = '0;
    hi = 0;
    rises = 0;
    pe = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (i < 20) dv[2] = ~dv[2];
      cyc(dv, 2'b10, '0, 1'b0);
      hi += int'(Edge[2]);
      if (Edge[2] && !pe) rises++;
      pe = Edge[2];
    end
    chk("fast_hi_cycles", hi, 22);
    chk("fast_rises", rises, 1);
    chk("fast_saturate", cnt_of(EdgeCount, 2), 15);

    // Levels held high through reset
    cyc(4'b1111, 2'b10, '0, 1'b1);
    cyc(4'b1111, 2'b10, '0, 1'b1);
    hi = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b1111, 2'b10, '0, 1'b0);
      hi += int'(AnyEdge);
      if (i >= 2) chk($sformatf("held_level_%0d", i), int'(Level), 15);
    end
    chk("held_no_edge", hi, 0);

    // Clear colliding with an edge event on channel 3 at count 7
    settle('0, 2'b10);
    dv = '0;
    for (int i = 0; i < 7; i++) begin
      dv[3] = ~dv[3];
      repeat (4) cyc(dv, 2'b10, '0, 1'b0);
    end
    chk("clr_pre_cnt", cnt_of(EdgeCount, 3), 7);
    dv[3] = ~dv[3];
    cyc(dv, 2'b10, '0, 1'b0);
    cyc(dv, 2'b10, '0, 1'b0);
    cyc(dv, 2'b10, 4'b1000, 1'b0);
    chk("clr_cnt", cnt_of(EdgeCount, 3), 0);
    hi = int'(Edge[3]);
    repeat (3) begin
      cyc(dv, 2'b10, '0, 1'b0);
      hi += int'(Edge[3]);
    end
    chk("clr_pulse_len", hi, 3);

    // Reset in the middle of a pulse on channel 0 at count 5
    settle('0, 2'b10);
    dv = '0;
    for (int i = 0; i < 4; i++) begin
      dv[0] = ~dv[0];
      repeat (4) cyc(dv, 2'b10, '0, 1'b0);
    end
    dv[0] = ~dv[0];
    repeat (3) cyc(dv, 2'b10, '0, 1'b0);
    chk("midrst_pre_edge", int'(Edge[0]), 1);
    chk("midrst_pre_cnt", cnt_of(EdgeCount, 0), 5);
    cyc(dv, 2'b10, '0, 1'b1);
    chk("midrst_edge", int'(Edge[0]), 0);
    chk("midrst_cnt", cnt_of(EdgeCount, 0), 0);

    // Random run against the model
    settle('0, 2'b00);
    for (int i = 0; i < 600; i++) begin
      cyc(CH'($urandom), 2'($urandom),
          ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0,
          $urandom_range(0, 79) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
